// File: rtl/aes128_enc_round_ctrl.sv
// aes128_enc_round_ctrl: iterative AES-128 encryption engine, one round per cycle.
// The shared round datapath performs SubBytes, ShiftRows, MixColumns and AddRoundKey.
// Round keys are expanded on the fly, and only one block is in flight at a time.
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   in_valid/in_ready            plaintext/key accept handshake (ready only in IDLE)
//   plaintext, key               128-bit inputs, byte 0 = [127:120], column-major
//   abort                        cancel the block in flight (RUN or DONE)
//   out_valid/out_ready          ciphertext handshake; ciphertext held while stalled
//   ciphertext                   128-bit result
//   round_idx                    current round number
//   busy                         engine not idle
module aes128_enc_round_ctrl #(
    parameter int unsigned NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    input  logic         abort,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext,
    output logic [3:0]   round_idx,
    output logic         busy
);

    localparam int unsigned RIDX_W     = 4;
    localparam logic [RIDX_W-1:0] LAST_ROUND = RIDX_W'(NR);

    // Byte i of the state is element i (column i/4, row i%4).
    typedef logic [0:15][7:0] blk_t;
    // Word 0 of the round key is key[127:96].
    typedef logic [0:3][31:0] wrd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } fsm_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Multiply by x in GF(2^8) mod x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // SubBytes followed by ShiftRows: row r rotates left by r columns.
    function automatic blk_t sub_shift(input blk_t s);
        blk_t o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[4'(4*c + r)] = SBOX[s[4'(4*((c + r) % 4) + r)]];
            end
        end
        return o;
    endfunction

    // MixColumns: each column multiplied by the circulant {02,03,01,01}.
    function automatic blk_t mix_columns(input blk_t s);
        blk_t o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[4'(4*c)];
            a1 = s[4'(4*c + 1)];
            a2 = s[4'(4*c + 2)];
            a3 = s[4'(4*c + 3)];
            o[4'(4*c)]     = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[4'(4*c + 1)] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[4'(4*c + 2)] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[4'(4*c + 3)] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    // One step of the AES-128 key schedule.
    function automatic wrd_t expand_key(input wrd_t k, input logic [7:0] rc);
        wrd_t o;
        o[0] = k[0] ^ sub_word({k[3][23:0], k[3][31:24]}) ^ {rc, 24'h0};
        o[1] = k[1] ^ o[0];
        o[2] = k[2] ^ o[1];
        o[3] = k[3] ^ o[2];
        return o;
    endfunction

    function automatic logic [7:0] rcon(input logic [RIDX_W-1:0] idx);
        logic [7:0] rc;
        case (idx)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    fsm_t fsm_q;
    blk_t state_q;
    wrd_t rkey_q;

    blk_t sr_c;
    blk_t mc_c;
    blk_t rnd_c;
    wrd_t rk_c;
    logic last_c;

    // Shared round datapath; the final round bypasses MixColumns.
    always_comb begin
        sr_c   = sub_shift(state_q);
        mc_c   = mix_columns(sr_c);
        rk_c   = expand_key(rkey_q, rcon(round_idx));
        last_c = (round_idx == LAST_ROUND);
        rnd_c  = (last_c ? sr_c : mc_c) ^ blk_t'(rk_c);
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q      <= ST_IDLE;
            state_q    <= '0;
            rkey_q     <= '0;
            round_idx  <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            ciphertext <= '0;
            busy       <= 1'b0;
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        state_q   <= blk_t'(plaintext ^ key);
                        rkey_q    <= wrd_t'(key);
                        round_idx <= RIDX_W'(1);
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        fsm_q     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        fsm_q     <= ST_IDLE;
                        round_idx <= '0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        state_q   <= rnd_c;
                        rkey_q    <= rk_c;
                        round_idx <= round_idx + RIDX_W'(1);
                        if (last_c) begin
                            ciphertext <= rnd_c;
                            out_valid  <= 1'b1;
                            fsm_q      <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    // Abort wins over a same-cycle output handshake.
                    if (abort || out_ready) begin
                        fsm_q     <= ST_IDLE;
                        round_idx <= '0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    fsm_q     <= ST_IDLE;
                    round_idx <= '0;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_enc_round_ctrl.sv
// tb_aes128_enc_round_ctrl: directed and randomized checks of the iterative AES-128 engine.
// The reference model derives the S-box from GF(2^8) inversion plus the affine map.
// It uses the word-oriented key schedule.
module tb_aes128_enc_round_ctrl;

    localparam int unsigned NR = 10;

    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    typedef logic [0:15][7:0] blk_t;
    typedef logic [0:3][7:0]  col_t;
    typedef logic [0:3][31:0] key_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] plaintext;
    logic [127:0] key;
    logic         abort;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ciphertext;
    logic [3:0]   round_idx;
    logic         busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes128_enc_round_ctrl #(.NR(NR)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .key        (key),
        .abort      (abort),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext),
        .round_idx  (round_idx),
        .busy       (busy)
    );

    // ---------------- reference model ----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[3'(i)]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    // S-box = affine(x^254); x^254 is the multiplicative inverse (0 maps to 0).
    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k, input int nr);
        logic [31:0] w [0:43];
        key_t        kw;
        blk_t        s;
        blk_t        t;
        col_t        a;
        col_t        rk;
        logic [7:0]  rc;
        logic [31:0] tmp;
        kw = k;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[6'(i)] = kw[2'(i)];
        for (int i = 4; i < 44; i++) begin
            tmp = w[6'(i - 1)];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_ref(tmp[31:24]), sbox_ref(tmp[23:16]), sbox_ref(tmp[15:8]), sbox_ref(tmp[7:0])};
                tmp = tmp ^ {rc, 24'h0};
                rc  = xt(rc);
            end
            w[6'(i)] = w[6'(i - 4)] ^ tmp;
        end
        s = pt;
        for (int c = 0; c < 4; c++) begin
            rk = w[6'(c)];
            for (int r = 0; r < 4; r++) s[4'(4*c + r)] = s[4'(4*c + r)] ^ rk[2'(r)];
        end
        for (int rnd = 1; rnd <= nr; rnd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[4'(4*c + r)] = sbox_ref(s[4'(4*((c + r) % 4) + r)]);
            if (rnd < nr) begin
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) a[2'(r)] = t[4'(4*c + r)];
                    for (int r = 0; r < 4; r++)
                        s[4'(4*c + r)] = gmul(8'h02, a[2'(r)]) ^ gmul(8'h03, a[2'((r + 1) % 4)])
                                       ^ a[2'((r + 2) % 4)] ^ a[2'((r + 3) % 4)];
                end
            end else begin
                s = t;
            end
            for (int c = 0; c < 4; c++) begin
                rk = w[6'(4*rnd + c)];
                for (int r = 0; r < 4; r++) s[4'(4*c + r)] = s[4'(4*c + r)] ^ rk[2'(r)];
            end
        end
        return s;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Waits (bounded) for out_valid; n = edges waited.
    task automatic wait_valid(input string tag, input int budget, output int n);
        n = 0;
        while (!out_valid && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_out_valid_seen"}, 128'(out_valid), 128'(1));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},   128'(in_ready),  128'(1));
        check({tag, "_out_valid"},  128'(out_valid), 128'(0));
        check({tag, "_ciphertext"}, ciphertext,      128'(0));
        check({tag, "_round_idx"},  128'(round_idx), 128'(0));
        check({tag, "_busy"},       128'(busy),      128'(0));
    endtask

    // One complete block from IDLE with `stall` cycles of out_ready low in DONE.
    task automatic run_block(input string tag, input logic [127:0] pt, input logic [127:0] k, input int stall);
        logic [127:0] exp;
        int n;
        exp = aes_ref(pt, k, NR);
        check({tag, "_in_ready"}, 128'(in_ready), 128'(1));
        out_ready = (stall == 0);
        plaintext = pt;
        key       = k;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_valid(tag, 40, n);
        check({tag, "_latency"}, 128'(n), 128'(NR));
        check({tag, "_ct"}, ciphertext, exp);
        repeat (stall) tick();
        check({tag, "_ct_held"}, ciphertext, exp);
        out_ready = 1'b1;
        tick();
        check({tag, "_out_valid_drop"}, 128'(out_valid), 128'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [127:0] pa, ka, pb, kb, exp;
        logic [127:0] got [2];
        int acc_t [2];
        int n, seen, acc, outs;
        logic pre;

        rst_n = 1'b0; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
        plaintext = '0; key = '0;
        tick();
        tick();
        rst_n = 1'b1;
        check_reset_values("reset");

        // FIPS-197 C.1 with latency and handshake checks.
        out_ready = 1'b1;
        plaintext = C1_PT; key = C1_KEY; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("c1_busy", 128'(busy), 128'(1));
        check("c1_in_ready_low", 128'(in_ready), 128'(0));
        check("c1_round1", 128'(round_idx), 128'(1));
        wait_valid("c1", 40, n);
        check("c1_latency", 128'(n), 128'(10));
        check("c1_ct_vector", ciphertext, C1_CT);
        check("c1_ct_model", ciphertext, aes_ref(C1_PT, C1_KEY, NR));
        tick();
        check("c1_idle_out_valid", 128'(out_valid), 128'(0));
        check("c1_idle_in_ready", 128'(in_ready), 128'(1));
        check("c1_idle_busy", 128'(busy), 128'(0));

        // FIPS-197 B with round_idx trace.
        plaintext = B_PT; key = B_KEY; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k < 10; k++) begin
            check($sformatf("b_round_%0d", k), 128'(round_idx), 128'(k));
            check($sformatf("b_no_valid_%0d", k), 128'(out_valid), 128'(0));
            tick();
        end
        check("b_round_10", 128'(round_idx), 128'(10));
        tick();
        check("b_out_valid", 128'(out_valid), 128'(1));
        check("b_ct_vector", ciphertext, B_CT);
        tick();

        // Backpressure for 20 cycles, with ignored in_valid during RUN/DONE.
        pa = rand128(); ka = rand128();
        exp = aes_ref(pa, ka, NR);
        out_ready = 1'b0;
        plaintext = pa; key = ka; in_valid = 1'b1;
        tick();
        plaintext = rand128(); key = rand128();
        wait_valid("bp", 40, n);
        check("bp_latency", 128'(n), 128'(10));
        for (int i = 0; i < 20; i++) begin
            check($sformatf("bp_valid_%0d", i), 128'(out_valid), 128'(1));
            check($sformatf("bp_ct_%0d", i), ciphertext, exp);
            check($sformatf("bp_in_ready_%0d", i), 128'(in_ready), 128'(0));
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_out_valid", 128'(out_valid), 128'(0));
        check("bp_release_in_ready", 128'(in_ready), 128'(1));

        // Abort at round 5.
        plaintext = rand128(); key = rand128(); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        check("abort_round5", 128'(round_idx), 128'(5));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", 128'(busy), 128'(0));
        check("abort_round_idx", 128'(round_idx), 128'(0));
        check("abort_out_valid", 128'(out_valid), 128'(0));
        check("abort_in_ready", 128'(in_ready), 128'(1));
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid) seen++;
            tick();
        end
        check("abort_never_valid", 128'(seen), 128'(0));
        run_block("abort_c1", C1_PT, C1_KEY, 0);
        check("abort_c1_vector", aes_ref(C1_PT, C1_KEY, NR) ^ C1_CT, 128'(0));

        // Abort in IDLE does not block a same-cycle accept.
        pa = rand128(); ka = rand128();
        exp = aes_ref(pa, ka, NR);
        plaintext = pa; key = ka; in_valid = 1'b1; abort = 1'b1;
        tick();
        in_valid = 1'b0; abort = 1'b0;
        check("idle_abort_busy", 128'(busy), 128'(1));
        wait_valid("idle_abort", 40, n);
        check("idle_abort_ct", ciphertext, exp);
        tick();

        // Reset mid-RUN with in_valid held during RUN.
        plaintext = rand128(); key = rand128(); in_valid = 1'b1;
        tick();
        check("rst_run_round1", 128'(round_idx), 128'(1));
        tick();
        check("rst_run_round2", 128'(round_idx), 128'(2));
        tick();
        check("rst_run_round3", 128'(round_idx), 128'(3));
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_reset_values("rst_run");
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid || busy) seen++;
            tick();
        end
        check("rst_run_stays_idle", 128'(seen), 128'(0));
        run_block("rst_after", rand128(), rand128(), 1);

        // Back-to-back with in_valid held high and out_ready=1.
        pa = rand128(); ka = rand128(); pb = rand128(); kb = rand128();
        out_ready = 1'b1;
        plaintext = pa; key = ka; in_valid = 1'b1;
        acc = 0; outs = 0;
        acc_t[0] = 0; acc_t[1] = 0; got[0] = '0; got[1] = '0;
        for (int t = 0; t < 60 && outs < 2; t++) begin
            pre = in_ready && in_valid;
            tick();
            if (pre && acc < 2) begin
                acc_t[acc] = t;
                acc++;
                if (acc == 1) begin
                    plaintext = pb; key = kb;
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid && outs < 2) begin
                got[outs] = ciphertext;
                outs++;
            end
        end
        in_valid = 1'b0;
        check("b2b_accepts", 128'(acc), 128'(2));
        check("b2b_outputs", 128'(outs), 128'(2));
        check("b2b_spacing", 128'(acc_t[1] - acc_t[0]), 128'(12));
        check("b2b_ct_a", got[0], aes_ref(pa, ka, NR));
        check("b2b_ct_b", got[1], aes_ref(pb, kb, NR));
        tick();

        // Randomized blocks with random output stalls.
        for (int j = 0; j < 6; j++) begin
            run_block($sformatf("rand%0d", j), rand128(), rand128(), int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
